// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_LOCK    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic        lock0,
  input  logic [31:0] a0,
  input  logic [31:0] wd0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rd0,
  input  logic        req1,
  input  logic        we1,
  input  logic        lock1,
  input  logic [31:0] a1,
  input  logic [31:0] wd1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rd1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] C_MAX_LOCK = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      rd0_q, rd0_d;
  logic [31:0]      rd1_q, rd1_d;

  logic             gnt_port;
  logic             keep_last;
  logic [31:0]      sel_a;
  logic [31:0]      rd_load;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    a_d        = a_q;
    wd_d       = wd_q;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    gnt_port   = 1'b0;
    keep_last  = 1'b0;
    sel_a      = 32'h0;
    rd_load    = 32'h0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // The previous winner keeps the grant only while it asks for lock and has budget left.
          keep_last = (last_q ? lock1 : lock0) && (lock_cnt_q < C_MAX_LOCK);
          if (req0 && req1) begin
            gnt_port = keep_last ? last_q : ~last_q;
          end else begin
            gnt_port = req1;
          end
          state_d = ACCESS;
          gnt_d   = gnt_port;
          last_d  = gnt_port;
          if (gnt_port == last_q) begin
            lock_cnt_d = (lock_cnt_q < C_MAX_LOCK) ? lock_cnt_q + 1'b1 : lock_cnt_q;
          end else begin
            lock_cnt_d = CNT_W'(1);
          end
          sel_a = gnt_port ? a1 : a0;
          we_d  = gnt_port ? we1 : we0;
          wd_d  = gnt_port ? wd1 : wd0;
          a_d   = sel_a;
          err_d = (sel_a[1:0] != 2'b00) || ({2'b00, sel_a[31:2]} >= 32'(DEPTH_WORDS));
        end
      end
      ACCESS: begin
        state_d = RESP;
        rd_load = (!we_q && !err_q) ? mem_rd : 32'h0;
        if (gnt_q) begin
          rd1_d = rd_load;
        end else begin
          rd0_d = rd_load;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      a_q        <= 32'h0;
      wd_q       <= 32'h0;
      rd0_q      <= 32'h0;
      rd1_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

  // Reset gates the write strobe combinationally so an aborted access never lands.
  assign mem_we = (state_q == ACCESS) && we_q && !err_q && !reset;
  assign mem_a  = (state_q == ACCESS) ? a_q  : 32'h0;
  assign mem_wd = (state_q == ACCESS) ? wd_q : 32'h0;

  assign ack0 = (state_q == RESP) && !gnt_q;
  assign ack1 = (state_q == RESP) &&  gnt_q;
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;
  assign rd0  = rd0_q;
  assign rd1  = rd1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] a0, wd0, a1, wd1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rd0, rd1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  logic clr_mem = 1'b1;

  logic [31:0] mem [64];
  int ack_port_q[$];
  int ack_cyc_q[$];

  dmem_arbiter #(.DEPTH_WORDS(64), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .a0(a0), .wd0(wd0),
    .ack0(ack0), .err0(err0), .rd0(rd0),
    .req1(req1), .we1(we1), .lock1(lock1), .a1(a1), .wd1(wd1),
    .ack1(ack1), .err1(err1), .rd1(rd1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_we && mem_a[31:2] < 30'd64) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) wr_cnt = wr_cnt + 1;
  end

  assign mem_rd = (mem_a[31:2] < 30'd64) ? mem[mem_a[7:2]] : 32'h0;

  always @(negedge clk) begin
    if (ack0) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
    if (ack1) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; a0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; a1 = 0; wd1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ack_port_q.delete();
    ack_cyc_q.delete();
  endtask

  // Called just after a rising edge with the FSM idle; lat counts negedges from the request.
  task automatic access(input int port, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output logic acc_we, output logic [31:0] acc_a);
    rd = 32'hX; err = 1'bX; lat = -1; acc_we = 1'bX; acc_a = 32'hX;
    if (port == 0) begin req0 = 1; we0 = we; a0 = a; wd0 = wd; end
    else begin req1 = 1; we1 = we; a1 = a; wd1 = wd; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) begin acc_we = mem_we; acc_a = mem_a; end
      if ((port == 0) ? ack0 : ack1) begin
        lat = i;
        rd  = (port == 0) ? rd0 : rd1;
        err = (port == 0) ? err0 : err1;
        check("other_ack", {31'b0, (port == 0) ? ack1 : ack0}, 32'h0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic wait_acks(input int n);
    int t;
    t = 0;
    while (ack_port_q.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    check("ack_count", 32'(ack_port_q.size() >= n), 32'h1);
  endtask

  logic [31:0] rd;
  logic        err, acc_we;
  logic [31:0] acc_a;
  int          lat;
  int          wr_base;
  int          exp_lock [5];

  initial begin
    do_reset();
    @(posedge clk);
    #1 clr_mem = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ack", {30'b0, ack0, ack1}, 32'h0);
    check("rst_err", {30'b0, err0, err1}, 32'h0);
    check("rst_rd0", rd0, 32'h0);
    check("rst_rd1", rd1, 32'h0);
    check("rst_mem", {mem_we, mem_a[30:0]}, 32'h0);
    @(posedge clk);
    #1;

    // Write then read back on port 0
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat, acc_we, acc_a);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", {31'b0, err}, 32'h0);
    check("wr_rd0", rd, 32'h0);
    check("wr_acc_we", {31'b0, acc_we}, 32'h1);
    check("wr_acc_a", acc_a, 32'h10);
    check("wr_mem", mem[4], 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0, rd, err, lat, acc_we, acc_a);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_err", {31'b0, err}, 32'h0);
    check("rd_rd0", rd, 32'hDEADBEEF);
    check("rd_acc_we", {31'b0, acc_we}, 32'h0);

    // Port 1: valid read, then out-of-range and misaligned writes
    wr_base = wr_cnt;
    access(1, 1'b0, 32'h10, 32'h0, rd, err, lat, acc_we, acc_a);
    check("p1_rd", rd, 32'hDEADBEEF);
    check("p1_rd0_hold", rd0, 32'hDEADBEEF);
    access(1, 1'b1, 32'h100, 32'hCAFEF00D, rd, err, lat, acc_we, acc_a);
    check("oor_lat", 32'(lat), 32'd2);
    check("oor_err", {31'b0, err}, 32'h1);
    check("oor_rd1", rd, 32'h0);
    access(1, 1'b1, 32'h0E, 32'h12345678, rd, err, lat, acc_we, acc_a);
    check("mis_err", {31'b0, err}, 32'h1);
    check("mis_rd1", rd, 32'h0);
    check("err_no_write", 32'(wr_cnt - wr_base), 32'h0);
    check("err_mem3", mem[3], 32'h0);
    check("err_mem4", mem[4], 32'hDEADBEEF);
    access(0, 1'b0, 32'h102, 32'h0, rd, err, lat, acc_we, acc_a);
    check("mis_rd_err0", {31'b0, err}, 32'h1);
    check("mis_rd_rd0", rd, 32'h0);

    // Both ports continuously requesting with lock low
    do_reset();
    req0 = 1; req1 = 1;
    wait_acks(4);
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_%0d", i), 32'(ack_port_q[i]), 32'(i % 2));
    check("alt_period", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd3);
    repeat (4) @(posedge clk);
    #1;

    // Port 0 holds lock against a continuously requesting port 1
    do_reset();
    lock0 = 1; req0 = 1; req1 = 1;
    wait_acks(5);
    exp_lock = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++)
      check($sformatf("lock_%0d", i), 32'(ack_port_q[i]), 32'(exp_lock[i]));
    repeat (4) @(posedge clk);
    #1;

    // Reset in the ACCESS cycle of a write to 0x20
    do_reset();
    wr_base = wr_cnt;
    req0 = 1; we0 = 1; a0 = 32'h20; wd0 = 32'h5A5A5A5A;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("abort_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0; req0 = 0; we0 = 0; a0 = 0; wd0 = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_no_write", 32'(wr_cnt - wr_base), 32'h0);
    check("abort_mem8", mem[8], 32'h0);
    check("abort_no_ack", 32'(ack_port_q.size()), 32'h0);
    check("abort_outs", {28'b0, ack0, ack1, err0, err1}, 32'h0);
    check("abort_mem_a", mem_a, 32'h0);
    check("abort_rd0", rd0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
